// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Saturation digit used when the result does not fit in the output digits.
    localparam logic [3:0] BCD_NINE = 4'h9;

    // Decimal digits needed to hold any bin_w-bit magnitude (log10(2) ~= 0.30103).
    function automatic int scratch_digits(input int bin_w);
        return (bin_w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_adj3.sv
// One double-dabble correction cell: a BCD digit above 4 gets 3 added so
// that the following left shift carries correctly into the next digit.
module bcd_adj3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    // Digit is at most 9 here, so the +3 never wraps a nibble.
    always_comb begin
        fixed = (digit > 4'd4) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/bin_bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one input bit per clock.
// Handshake: START is sampled only in IDLE or DONE; BUSY is high for the
// BIN_W shift cycles; DONE pulses for one cycle and BCD/NEG/OVF change on
// the same edge that raises DONE, then hold until the next DONE.
module bin_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 17,
    parameter int DIGITS = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  SIGNED,
    input  logic [BIN_W-1:0]      A,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  NEG,
    output logic                  OVF
);

    localparam int SCR_D = scratch_digits(BIN_W);
    // Scratch view padded so the output slice exists even when DIGITS > SCR_D.
    localparam int EXT_D = (SCR_D > DIGITS) ? SCR_D : DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t               state_q;
    state_t               state_d;
    logic [4*SCR_D-1:0]   scr_q;
    logic [4*SCR_D-1:0]   scr_adj;
    logic [4*SCR_D-1:0]   scr_next;
    logic [BIN_W-1:0]     mag_q;
    logic [BIN_W-1:0]     mag_load;
    logic [CNT_W-1:0]     cnt_q;
    logic                 neg_q;
    logic                 load;
    logic                 last;
    logic [4*EXT_D-1:0]   scr_ext;
    logic                 ovf_c;
    logic [4*DIGITS-1:0]  bcd_c;

    // Per-digit add-3 correction ahead of each shift.
    for (genvar g = 0; g < SCR_D; g++) begin : g_adj
        bcd_adj3 u_adj (
            .digit (scr_q[4*g +: 4]),
            .fixed (scr_adj[4*g +: 4])
        );
    end

    // A new conversion is accepted only when not shifting.
    always_comb begin
        load     = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        last     = (state_q == ST_SHIFT) && (cnt_q == CNT_ONE);
        mag_load = (SIGNED && A[BIN_W-1]) ? (~A) + {{(BIN_W-1){1'b0}}, 1'b1} : A;
        scr_next = {scr_adj[4*SCR_D-2:0], mag_q[BIN_W-1]};
    end

    // Result formatting from the scratch as it will be after the final shift.
    always_comb begin
        scr_ext                = '0;
        scr_ext[4*SCR_D-1:0]   = scr_next;
        ovf_c                  = 1'b0;
        for (int i = DIGITS; i < EXT_D; i++) begin
            ovf_c = ovf_c | (|scr_ext[4*i +: 4]);
        end
        bcd_c = ovf_c ? {DIGITS{BCD_NINE}} : scr_ext[4*DIGITS-1:0];
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SHIFT lasts exactly BIN_W cycles; START there is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (START) state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == CNT_ONE) state_d = ST_DONE;
            ST_DONE:  state_d = START ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state, so BUSY and DONE are exclusive.
    always_comb begin
        BUSY = (state_q == ST_SHIFT);
        DONE = (state_q == ST_DONE);
    end

    // Datapath: load, shift-and-add-3 per cycle, register result on the last shift.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scr_q <= '0;
            mag_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            BCD   <= '0;
            NEG   <= 1'b0;
            OVF   <= 1'b0;
        end else if (load) begin
            scr_q <= '0;
            mag_q <= mag_load;
            cnt_q <= CNT_LOAD;
            neg_q <= SIGNED & A[BIN_W-1];
        end else if (state_q == ST_SHIFT) begin
            scr_q <= scr_next;
            mag_q <= {mag_q[BIN_W-2:0], 1'b0};
            cnt_q <= cnt_q - CNT_ONE;
            if (last) begin
                BCD <= bcd_c;
                NEG <= neg_q;
                OVF <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Bench for bin_bcd_seq: a default 17-bit/5-digit instance and an
// 8-bit/2-digit instance, each checked by a scoreboard fed from an
// arithmetic reference model.
module tb_bin_bcd_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT A: BIN_W=17, DIGITS=5 ----------------
    logic        a_start, a_sgn;
    logic [16:0] a_val;
    logic        a_busy, a_done, a_neg, a_ovf;
    logic [19:0] a_bcd;

    bin_bcd_seq #(.BIN_W(17), .DIGITS(5)) dut_a (
        .CLK(clk), .RST(rst), .START(a_start), .SIGNED(a_sgn), .A(a_val),
        .BUSY(a_busy), .DONE(a_done), .BCD(a_bcd), .NEG(a_neg), .OVF(a_ovf)
    );

    // ---------------- DUT B: BIN_W=8, DIGITS=2 ----------------
    logic       b_start, b_sgn;
    logic [7:0] b_val;
    logic       b_busy, b_done, b_neg, b_ovf;
    logic [7:0] b_bcd;

    bin_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .CLK(clk), .RST(rst), .START(b_start), .SIGNED(b_sgn), .A(b_val),
        .BUSY(b_busy), .DONE(b_done), .BCD(b_bcd), .NEG(b_neg), .OVF(b_ovf)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int a_dones  = 0;
    int b_dones  = 0;
    int a_issued = 0;
    int b_issued = 0;
    logic [21:0] exp_a[$];
    logic [9:0]  exp_b[$];
    logic [21:0] e_a;
    logic [9:0]  e_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the magnitude, decimal digits by /10.
    function automatic void ref_model(input int bin_w, input int digits, input bit sgn,
                                      input longint unsigned val,
                                      output logic [19:0] bcd, output logic neg,
                                      output logic ovf);
        longint unsigned mag, lim;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        neg = sgn && val[bin_w-1];
        mag = neg ? ((64'd1 << bin_w) - val) : val;
        ovf = (mag >= lim);
        bcd = '0;
        for (int i = 0; i < digits; i++) begin
            if (ovf) begin
                bcd[4*i +: 4] = 4'h9;
            end else begin
                bcd[4*i +: 4] = 4'(mag % 10);
                mag = mag / 10;
            end
        end
    endfunction

    task automatic push_a(input bit sgn, input logic [16:0] val);
        logic [19:0] bcd; logic neg, ovf;
        ref_model(17, 5, sgn, longint'(val), bcd, neg, ovf);
        exp_a.push_back({ovf, neg, bcd});
        a_issued++;
    endtask

    task automatic push_b(input bit sgn, input logic [7:0] val);
        logic [19:0] bcd; logic neg, ovf;
        ref_model(8, 2, sgn, longint'(val), bcd, neg, ovf);
        exp_b.push_back({ovf, neg, bcd[7:0]});
        b_issued++;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_done) begin
            a_dones++;
            chk("a_busy_done_exclusive", 64'(a_busy), 64'd0);
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_done actual_bcd=%0h required=no_done", a_bcd);
            end else begin
                e_a = exp_a.pop_front();
                chk("a_result", 64'({a_ovf, a_neg, a_bcd}), 64'(e_a));
            end
        end
        if (b_done) begin
            b_dones++;
            chk("b_busy_done_exclusive", 64'(b_busy), 64'd0);
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_done actual_bcd=%0h required=no_done", b_bcd);
            end else begin
                e_b = exp_b.pop_front();
                chk("b_result", 64'({b_ovf, b_neg, b_bcd}), 64'(e_b));
            end
        end
    end

    // ---------------- drivers ----------------
    // Bounded wait for DONE on A from #1 after a load edge; returns edges waited
    // and the number of samples where BUSY was high.
    task automatic wait_a(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (!a_done && lat < 100) begin
            if (a_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_b(output int lat, output int busy_n);
        lat = 0; busy_n = 0;
        while (!b_done && lat < 100) begin
            if (b_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic conv_a(input bit sgn, input logic [16:0] val);
        int lat, busy_n;
        @(negedge clk);
        a_start = 1'b1; a_sgn = sgn; a_val = val;
        push_a(sgn, val);
        @(posedge clk); #1;
        a_start = 1'b0;
        a_sgn   = 1'($urandom_range(0, 1));
        a_val   = 17'($urandom);
        wait_a(lat, busy_n);
        chk("a_latency", 64'(lat), 64'd17);
        chk("a_busy_cycles", 64'(busy_n), 64'd17);
    endtask

    task automatic conv_b(input bit sgn, input logic [7:0] val);
        int lat, busy_n;
        @(negedge clk);
        b_start = 1'b1; b_sgn = sgn; b_val = val;
        push_b(sgn, val);
        @(posedge clk); #1;
        b_start = 1'b0;
        b_val   = 8'($urandom);
        wait_b(lat, busy_n);
        chk("b_latency", 64'(lat), 64'd8);
        chk("b_busy_cycles", 64'(busy_n), 64'd8);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat, busy_n, dones_before;
        rst = 1'b1;
        a_start = 1'b1; a_sgn = 1'b0; a_val = 17'd77;
        b_start = 1'b1; b_sgn = 1'b0; b_val = 8'd77;
        repeat (3) @(posedge clk);
        #1;
        chk("a_reset_outputs", 64'({a_busy, a_done, a_neg, a_ovf, a_bcd}), 64'd0);
        chk("b_reset_outputs", 64'({b_busy, b_done, b_neg, b_ovf, b_bcd}), 64'd0);
        a_start = 1'b0; b_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed conversions on the default instance.
        conv_a(1'b0, 17'd12345);
        conv_a(1'b0, 17'd131071);
        conv_a(1'b0, 17'd99999);
        conv_a(1'b0, 17'd0);
        conv_a(1'b1, 17'h1FFFF);
        conv_a(1'b1, 17'h10000);
        conv_a(1'b1, 17'h0FFFF);
        repeat (3) @(posedge clk);

        // START pulses while shifting are dropped; START held into DONE chains a new one.
        @(negedge clk);
        a_start = 1'b1; a_sgn = 1'b0; a_val = 17'd42;
        push_a(1'b0, 17'd42);
        @(posedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            a_val   = 17'd5;
            a_start = c[0];
        end
        @(negedge clk);
        a_start = 1'b1; a_val = 17'd7;
        @(posedge clk); #1;
        chk("a_done_after_ignored_starts", 64'(a_done), 64'd1);
        push_a(1'b0, 17'd7);
        @(posedge clk); #1;
        chk("a_back_to_back_busy", 64'(a_busy), 64'd1);
        a_start = 1'b0;
        wait_a(lat, busy_n);
        chk("a_back_to_back_latency", 64'(lat), 64'd17);
        repeat (3) @(posedge clk);

        // Reset in the middle of a conversion, together with START.
        @(negedge clk);
        a_start = 1'b1; a_sgn = 1'b0; a_val = 17'd123;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; a_start = 1'b1; a_val = 17'd999;
        @(posedge clk); #1;
        chk("a_abort_outputs", 64'({a_busy, a_done, a_neg, a_ovf, a_bcd}), 64'd0);
        rst = 1'b0; a_start = 1'b0;
        dones_before = a_dones;
        repeat (25) @(posedge clk);
        chk("a_no_done_after_abort", 64'(a_dones), 64'(dones_before));
        conv_a(1'b0, 17'd300);

        // Randomized conversions.
        for (int n = 0; n < 40; n++) begin
            conv_a(1'($urandom_range(0, 1)), 17'($urandom));
        end

        // Narrow instance: directed then exhaustive in both modes.
        conv_b(1'b0, 8'd255);
        conv_b(1'b0, 8'd99);
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                conv_b(s[0], v[7:0]);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("a_queue_drained", 64'(exp_a.size()), 64'd0);
        chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
        chk("a_done_count", 64'(a_dones), 64'(a_issued));
        chk("b_done_count", 64'(b_dones), 64'(b_issued));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
